// File: rtl/bin_to_ascii_tx.sv
// Serialises a snapshot of NUM_CH 2-bit valve codes as one ASCII status line
// ('0','1','m','?' per channel, optional CR/LF) over a valid/ready byte interface.
module bin_to_ascii_tx #(
  parameter int NUM_CH  = 8,
  parameter bit TERM_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2*NUM_CH-1:0] codes,
  output logic                busy,
  output logic                done,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready
);

  localparam int IDX_W  = $clog2(NUM_CH) + 1;
  // Snapshot padded to a power of two so the variable channel select is always in range.
  localparam int SNAP_W = 2 ** (IDX_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEND_CH = 3'd1;
  localparam logic [2:0] SEND_CR = 3'd2;
  localparam logic [2:0] SEND_LF = 3'd3;
  localparam logic [2:0] FIN     = 3'd4;

  logic [2:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [SNAP_W-1:0] snapshot;
  logic [1:0]        next_code;
  logic              xfer;

  function automatic logic [7:0] enc(input logic [1:0] code);
    case (code)
      2'b00:   enc = 8'h30;
      2'b01:   enc = 8'h31;
      2'b10:   enc = 8'h6D;
      default: enc = 8'h3F;
    endcase
  endfunction

  assign xfer      = tx_valid & tx_ready;
  assign idx_next  = idx + IDX_W'(1);
  assign next_code = snapshot[{idx_next, 1'b0} +: 2];
  assign busy      = (state == SEND_CH) || (state == SEND_CR) || (state == SEND_LF);
  assign done      = (state == FIN);

  // tx_data only moves on a transfer, so it is held steady through any stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      snapshot <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snapshot <= SNAP_W'(codes);
            idx      <= '0;
            tx_data  <= enc(codes[1:0]);
            tx_valid <= 1'b1;
            state    <= SEND_CH;
          end
        end
        SEND_CH: begin
          if (xfer) begin
            if (idx != LAST_IDX) begin
              idx     <= idx_next;
              tx_data <= enc(next_code);
            end else if (TERM_EN) begin
              tx_data <= 8'h0D;
              state   <= SEND_CR;
            end else begin
              tx_valid <= 1'b0;
              state    <= FIN;
            end
          end
        end
        SEND_CR: begin
          if (xfer) begin
            tx_data <= 8'h0A;
            state   <= SEND_LF;
          end
        end
        SEND_LF: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            state    <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_ascii_tx.sv
// Directed bench for bin_to_ascii_tx: a 4-channel CR/LF instance and a
// 1-channel unterminated instance share one clock and reset.
module tb_bin_to_ascii_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] codes = 8'h00;
  logic       busy, done, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b1;

  logic       start_b = 1'b0;
  logic [1:0] codes_b = 2'b00;
  logic       busy_b, done_b, tx_valid_b;
  logic [7:0] tx_data_b;
  logic       tx_ready_b = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] qb[$];
  int done_cnt = 0;
  int done_cnt_b = 0;
  int stall_err = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit rdy_mode = 1'b0;
  int pc = 0;
  int n;

  logic [7:0] exp_line [6] = '{8'h30, 8'h31, 8'h6D, 8'h3F, 8'h0D, 8'h0A};

  bin_to_ascii_tx #(.NUM_CH(4), .TERM_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .codes(codes), .busy(busy), .done(done),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  bin_to_ascii_tx #(.NUM_CH(1), .TERM_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .codes(codes_b), .busy(busy_b), .done(done_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b)
  );

  always #5 clk = ~clk;

  // Transfers are recorded on the falling edge, ahead of the rising edge that takes them.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && tx_data !== prev_data) stall_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) q.push_back(tx_data);
      if (done) done_cnt++;
      if (tx_valid_b && tx_ready_b) qb.push_back(tx_data_b);
      if (done_b) done_cnt_b++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode) begin
      tx_ready = (pc % 3 == 0);
      pc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q.delete();
    qb.delete();
    done_cnt   = 0;
    done_cnt_b = 0;
    stall_err  = 0;
  endtask

  // Returns the number of cycles after acceptance until done rises, or fails on timeout.
  task automatic wait_done_a(output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cycles++;
      if (done) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_a(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_first"}, 32'(tx_data), 32'h30);
  endtask

  task automatic check_line(input string tag);
    chk({tag, "_len"}, 32'(q.size()), 32'd6);
    for (int i = 0; i < 6 && i < q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(q[i]), 32'(exp_line[i]));
    chk({tag, "_dones"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1) full-rate line
    clear_mon();
    codes = 8'b11_10_01_00;
    start_a("t1");
    wait_done_a(n);
    chk("t1_latency", 32'(n), 32'd6);
    chk("t1_busy_fin", 32'(busy), 32'd0);
    tick();
    tick();
    check_line("t1");

    // 2) stalled line: ready pattern 1-0-0 repeating
    clear_mon();
    pc = 0;
    rdy_mode = 1'b1;
    start_a("t2");
    wait_done_a(n);
    tick();
    tick();
    rdy_mode = 1'b0;
    tx_ready = 1'b1;
    check_line("t2");
    chk("t2_stall_hold", 32'(stall_err), 32'd0);

    // 3) codes change right after acceptance
    clear_mon();
    codes = 8'b11_10_01_00;
    start_a("t3");
    codes = 8'hFF;
    wait_done_a(n);
    tick();
    tick();
    check_line("t3");

    // 4) second start pulse mid-line is ignored
    clear_mon();
    codes = 8'b11_10_01_00;
    start_a("t4");
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done_a(n);
    for (int i = 0; i < 10; i++) tick();
    check_line("t4");
    chk("t4_idle", 32'(busy), 32'd0);

    // 5) reset while byte 2 is on the bus
    clear_mon();
    start_a("t5");
    tick();
    chk("t5_byte2", 32'(tx_data), 32'h31);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(tx_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    clear_mon();
    start_a("t5r");
    wait_done_a(n);
    tick();
    tick();
    check_line("t5r");

    // 6) single channel, no terminator
    clear_mon();
    codes_b = 2'b10;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("t6_valid", 32'(tx_valid_b), 32'd1);
    chk("t6_data", 32'(tx_data_b), 32'h6D);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n++;
      if (done_b) break;
    end
    chk("t6_latency", 32'(n), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_len", 32'(qb.size()), 32'd1);
    if (qb.size() > 0) chk("t6_byte", 32'(qb[0]), 32'h6D);
    chk("t6_dones", 32'(done_cnt_b), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
